// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types, constants and baud-divider helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Encodings coincide with uart_tx where the state names match.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BYTE  = 3'd2,
        STOP_BIT   = 3'd3,
        CLEANUP    = 3'd4,
        PARITY_BIT = 3'd5,
        WAIT_HIGH  = 3'd6
    } uart_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_2ff
//  Brief    : Two-flop synchroniser for a single asynchronous input.
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver, mid-bit sampling, one-cycle byte strobe.
//             Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE       = 9600,
    parameter int CLOCK_FREQUENCY = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_active,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_last_bit = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    uart_state_t               r_state,     w_state_next;
    logic [CNT_W-1:0]          r_clk_cnt,   w_clk_cnt_next;
    logic [2:0]                r_bit_idx,   w_bit_idx_next;
    logic [UART_DATA_BITS-1:0] r_shift,     w_shift_next;
    logic [UART_DATA_BITS-1:0] r_byte,      w_byte_next;
    logic                      r_dv,        w_dv_next;
    logic                      r_frame_err, w_frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                      r_parity_bit, w_parity_bit_next;
    logic                      r_parity_err, w_parity_err_next;
`endif

    uart_sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_async (i_rx_serial),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_dv        <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_byte      <= w_byte_next;
            r_dv        <= w_dv_next;
            r_frame_err <= w_frame_err_next;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= w_parity_bit_next;
            r_parity_err <= w_parity_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clk_cnt_next   = r_clk_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_byte_next      = r_byte;
        w_dv_next        = 1'b0;
        w_frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_bit_next = r_parity_bit;
        w_parity_err_next = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                if (!w_rx_s) begin
                    w_state_next = START_BIT;
                end
            end
            START_BIT: begin
                if (r_clk_cnt == c_half_cnt) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = w_rx_s ? IDLE : DATA_BYTE;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            DATA_BYTE: begin
                if (r_clk_cnt == c_last_cnt) begin
                    w_clk_cnt_next          = '0;
                    w_shift_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == c_last_bit) begin
                        w_bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_next   = PARITY_BIT;
`else
                        w_state_next   = STOP_BIT;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (r_clk_cnt == c_last_cnt) begin
                    w_clk_cnt_next    = '0;
                    w_parity_bit_next = w_rx_s;
                    w_state_next      = STOP_BIT;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
`endif
            // Leaving at the stop-bit midpoint re-arms the receiver half a bit early.
            STOP_BIT: begin
                if (r_clk_cnt == c_last_cnt) begin
                    w_clk_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if ((^r_shift) != r_parity_bit) begin
                            w_parity_err_next = 1'b1;
                        end else begin
                            w_dv_next   = 1'b1;
                            w_byte_next = r_shift;
                        end
`else
                        w_dv_next   = 1'b1;
                        w_byte_next = r_shift;
`endif
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = WAIT_HIGH;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
                end
            end
            // A held-low line (break) must not be mistaken for a new start bit.
            WAIT_HIGH: begin
                w_clk_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase
    end

    assign o_rx_dv        = r_dv;
    assign o_rx_byte      = r_byte;
    assign o_rx_active    = (r_state != IDLE);
    assign o_rx_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_rx_parity_err = r_parity_err;
`else
    assign o_rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
